// File: rtl/pe_wb_collector_pkg.sv
// Shared types and sizes for the PE column writeback collector.
package pe_wb_collector_pkg;

   typedef enum logic [2:0] {
      WB_IDLE,
      WB_ISSUE,
      WB_CAPWAIT,
      WB_PUSH,
      WB_DONE
   } wb_state_t;

   localparam int WB_WORDS  = 4;
   localparam int WB_WORD_W = 32;
   localparam int WB_LINE_W = 128;

endpackage

// File: rtl/pe_wb_collector.sv
// Drains each PE's 4-word accumulator regfile, packs the words into a 128-bit
// line and streams one line per PE (row 0 first) over valid/ready.
module pe_wb_collector
   import pe_wb_collector_pkg::*;
#(
   parameter  int ROWS  = 4,
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [ROWS-1:0]           wben,
   output logic [ROWS-1:0]           out_ready,
   input  logic [ROWS*WB_WORD_W-1:0] out_sum,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [WB_LINE_W-1:0]      m_data,
   output logic [ROW_W-1:0]          m_row
);

   wb_state_t                             state_q, state_d;
   logic [1:0]                            word_q, word_d;
   logic [ROW_W-1:0]                      row_q, row_d;
   logic                                  cap_valid_q;
   logic [1:0]                            cap_word_q;
   logic [WB_WORDS-1:0][WB_WORD_W-1:0]    line_q;
   logic [WB_WORD_W-1:0]                  sel_word;
   logic [ROWS-1:0]                       row_onehot;

   // The PE registers its popped word, so capture lags the pop by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WB_IDLE;
         word_q      <= '0;
         row_q       <= '0;
         cap_valid_q <= 1'b0;
         cap_word_q  <= '0;
         line_q      <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         row_q       <= row_d;
         cap_valid_q <= (state_q == WB_ISSUE);
         cap_word_q  <= word_q;
         if (cap_valid_q)
            line_q[cap_word_q] <= sel_word;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      row_d   = row_q;
      unique case (state_q)
         WB_IDLE: begin
            if (start) begin
               state_d = WB_ISSUE;
               word_d  = '0;
               row_d   = '0;
            end
         end
         WB_ISSUE: begin
            word_d = word_q + 2'd1;
            if (word_q == 2'd3)
               state_d = WB_CAPWAIT;
         end
         WB_CAPWAIT: state_d = WB_PUSH;
         WB_PUSH: begin
            if (m_ready) begin
               if (row_q == ROW_W'(ROWS - 1)) begin
                  state_d = WB_DONE;
               end else begin
                  state_d = WB_ISSUE;
                  row_d   = row_q + 1'b1;
                  word_d  = '0;
               end
            end
         end
         WB_DONE: state_d = WB_IDLE;
         default: state_d = WB_IDLE;
      endcase
   end

   always_comb begin
      sel_word   = '0;
      row_onehot = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == ROW_W'(r)) begin
            sel_word      = out_sum[r*WB_WORD_W +: WB_WORD_W];
            row_onehot[r] = 1'b1;
         end
      end
      busy      = (state_q == WB_ISSUE) || (state_q == WB_CAPWAIT) || (state_q == WB_PUSH);
      done      = (state_q == WB_DONE);
      wben      = ((state_q == WB_ISSUE) || (state_q == WB_CAPWAIT)) ? row_onehot : '0;
      out_ready = (state_q == WB_ISSUE) ? row_onehot : '0;
      m_valid   = (state_q == WB_PUSH);
      m_data    = line_q;
      m_row     = row_q;
   end

endmodule
